apb_timer: RTL and testbench
============================

Name: apb_timer

Overview:
- APB slave downstream of the AXI-to-APB bridge: a programmable down-counting timer with prescaler, one-shot/auto-reload modes and a level interrupt.
- Zero-wait-state slave with no PREADY. Errors are reported on PSLVERROR.
- The bridge holds PSEL and PENABLE high together for the whole AXI transaction, which can last multiple cycles. Each access must therefore commit exactly once.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; must be ≥ COUNT_WIDTH and ≥ 16.
- COUNT_WIDTH, 32, timer counter width.
- DEC_BITS, 12, low PADDR bits decoded; upper bits are ignored.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- PADDR  in  ADDR_WIDTH  register address.
- PWDATA  in  DATA_WIDTH  write data.
- PWRITE  in  1  1 = write, 0 = read.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PRDATA  out  DATA_WIDTH  read data; combinational from PADDR.
- PSLVERROR  out  1  slave error; combinational.
- IRQ  out  1  level interrupt, registered.
- CAPTURE_IN  in  1  capture trigger; present only with APB_TIMER_CAPTURE_EN.

Behaviour:
- Clocking: one clock, ACLK. ARESET is synchronous and active-high.
- Reset values: all registers 0. IRQ=0, PRDATA=0, PSLVERROR=0, access-done flag=0.
- Register map (offset = PADDR[DEC_BITS-1:0]):
  - 0x00 CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE. All other bits read 0.
  - 0x04 LOAD, RW.
  - 0x08 COUNT, RO.
  - 0x0C STATUS: bit0 EXPIRED, write-1-to-clear.
- Access strobe: acc = PSEL & PENABLE.
  - A write commits on the first ACLK edge where acc=1 and done=0; done is then set to 1.
  - done clears on the first edge where PSEL=0.
  - While done=1, repeated acc cycles do not commit.
  - Reads have no side effects.
- PRDATA: selected register value while PSEL=1, otherwise 0. It is valid in the same cycle PSEL rises.
- PSLVERROR = acc & (PADDR[1:0]≠0 | unmapped offset | write to COUNT).
  - An errored write changes no state.
  - An errored read returns 0.
- Prescaler:
  - Counter pre counts 0..PRESCALE while EN=1.
  - tick = EN & (pre==PRESCALE); pre wraps to 0 on tick.
  - PRESCALE=0 gives a tick every cycle.
  - pre is held at 0 while EN=0.
- Counter, on each tick:
  - If COUNT≠0: COUNT decrements by 1.
  - If COUNT==0: EXPIRED←1. With AUTO_RELOAD=1, COUNT←LOAD. Otherwise EN←0 (one-shot) and COUNT stays 0.
  - Expiry period is (LOAD+1)*(PRESCALE+1) cycles.
  - LOAD=0 with auto-reload expires on every tick.
- Writes:
  - A committed LOAD write also sets COUNT←PWDATA and pre←0.
  - A CTRL write that takes EN from 0→1 sets pre←0.
- Simultaneous events:
  - A committed CTRL or LOAD write in the same cycle as a tick wins. That tick is discarded: no decrement, no EXPIRED.
  - A STATUS W1C in the same cycle as an expiry: set wins, EXPIRED stays 1.
- IRQ is registered as EXPIRED & IRQ_EN, so it follows with a 1-cycle lag.
- Reset mid-access: done←0. If acc is still high after ARESET deasserts, the pending write commits once more.
- Width: COUNT/LOAD are COUNT_WIDTH bits; upper PWDATA bits are ignored and read back as 0.

Optional Feature:
- Macro: APB_TIMER_CAPTURE_EN.
- When defined:
  - CAPTURE_IN is passed through a 2-flop synchronizer followed by rising-edge detection.
  - On each detected edge, register 0x10 CAPTURE (RO) ← COUNT, and STATUS bit1 CAP_VALID←1 (W1C, set wins).
  - Edge-to-update latency is 3 ACLK cycles.
  - Writing 0x10 asserts PSLVERROR.
- When not defined:
  - There is no CAPTURE_IN port.
  - Offset 0x10 is unmapped and asserts PSLVERROR.
  - STATUS bit1 reads 0.

Test Plan:
- Write LOAD=5, then CTRL=0x0000_0007 (PRESCALE=0, auto-reload, IRQ_EN) → EXPIRED sets every 6 cycles. IRQ rises 1 cycle after EXPIRED. COUNT read sequence is 5,4,…,0,5.
- One-shot: LOAD=3, CTRL=0x0000_0301 (PRESCALE=3) → expiry after 16 cycles, EN reads 0, COUNT holds 0, no further expiry.
- Hold PSEL=PENABLE=1 for 4 cycles on a write of 0x0C=0x1 while EXPIRED=1 → exactly one clear, EXPIRED=0. Forcing an expiry during cycles 2–4 of that access leaves EXPIRED=1.
- Write COUNT (0x08), access 0x02, read 0x40 → PSLVERROR=1 on each access. No register changes, read data 0.
- Write LOAD=10 in the same cycle as a tick with COUNT=1 → COUNT=10 next cycle, EXPIRED unchanged.
- With APB_TIMER_CAPTURE_EN: pulse CAPTURE_IN while COUNT=0x20 and counting at PRESCALE=0 → CAPTURE=0x1D, CAP_VALID=1.

Source files
------------

// File: rtl/apb_timer.sv
// apb_timer: APB down-counting timer with prescaler, one-shot/auto-reload and level IRQ.
// Define APB_TIMER_CAPTURE_EN to add the CAPTURE_IN input-capture unit at offset 0x10.
module apb_timer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32,
    parameter int DEC_BITS    = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PWRITE,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERROR,
`ifdef APB_TIMER_CAPTURE_EN
    input  logic                  CAPTURE_IN,
`endif
    output logic                  IRQ
);

    localparam logic [DEC_BITS-1:0] OFF_CTRL   = DEC_BITS'(12'h000);
    localparam logic [DEC_BITS-1:0] OFF_LOAD   = DEC_BITS'(12'h004);
    localparam logic [DEC_BITS-1:0] OFF_COUNT  = DEC_BITS'(12'h008);
    localparam logic [DEC_BITS-1:0] OFF_STATUS = DEC_BITS'(12'h00C);
    localparam logic [DEC_BITS-1:0] OFF_CAP    = DEC_BITS'(12'h010);

    logic [DEC_BITS-1:0]    off;
    logic                   acc;
    logic                   done;
    logic                   err;
    logic                   commit;
    logic                   hit_ctrl;
    logic                   hit_load;
    logic                   hit_count;
    logic                   hit_status;
    logic                   hit_cap;
    logic                   mapped;
    logic                   wr_ro;
    logic                   wr_ctrl;
    logic                   wr_load;
    logic                   wr_status;
    logic                   start;
    logic                   tick;
    logic                   tick_ok;
    logic                   expire;
    logic                   en;
    logic                   auto_reload;
    logic                   irq_en;
    logic [7:0]             prescale;
    logic [7:0]             pre;
    logic [COUNT_WIDTH-1:0] load;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] wdata_cnt;
    logic                   expired;
    logic [DATA_WIDTH-1:0]  rdata;
    logic [DATA_WIDTH-1:0]  ctrl_rd;
    logic [DATA_WIDTH-1:0]  status_rd;
    logic                   unused_addr;

`ifdef APB_TIMER_CAPTURE_EN
    logic [2:0]             cap_sync;
    logic                   cap_edge;
    logic                   cap_valid;
    logic [COUNT_WIDTH-1:0] cap;
`endif

    assign unused_addr = ^PADDR[ADDR_WIDTH-1:DEC_BITS];

    assign off        = PADDR[DEC_BITS-1:0];
    assign acc        = PSEL & PENABLE;
    assign hit_ctrl   = (off == OFF_CTRL);
    assign hit_load   = (off == OFF_LOAD);
    assign hit_count  = (off == OFF_COUNT);
    assign hit_status = (off == OFF_STATUS);
`ifdef APB_TIMER_CAPTURE_EN
    assign hit_cap    = (off == OFF_CAP);
`else
    assign hit_cap    = 1'b0;
`endif
    assign mapped  = hit_ctrl | hit_load | hit_count | hit_status | hit_cap;
    assign wr_ro   = PWRITE & (hit_count | hit_cap);
    assign err     = acc & ((PADDR[1:0] != 2'b00) | ~mapped | wr_ro);
    assign commit  = acc & ~done & PWRITE & ~err;

    assign PSLVERROR = err;

    assign wr_ctrl   = commit & hit_ctrl;
    assign wr_load   = commit & hit_load;
    assign wr_status = commit & hit_status;
    assign wdata_cnt = PWDATA[COUNT_WIDTH-1:0];
    assign start     = wr_ctrl & ~en & PWDATA[0];

    // A register write in the same cycle as a tick swallows that tick.
    assign tick    = en & (pre == prescale);
    assign tick_ok = tick & ~wr_ctrl & ~wr_load;
    assign expire  = tick_ok & (count == '0);

    assign ctrl_rd = DATA_WIDTH'({prescale, 5'b0, irq_en, auto_reload, en});
`ifdef APB_TIMER_CAPTURE_EN
    assign status_rd = DATA_WIDTH'({cap_valid, expired});
`else
    assign status_rd = DATA_WIDTH'(expired);
`endif

    // Read mux; unmapped or misaligned offsets read as zero.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            hit_ctrl:   rdata = ctrl_rd;
            hit_load:   rdata = DATA_WIDTH'(load);
            hit_count:  rdata = DATA_WIDTH'(count);
            hit_status: rdata = status_rd;
`ifdef APB_TIMER_CAPTURE_EN
            hit_cap:    rdata = DATA_WIDTH'(cap);
`endif
            default:    rdata = '0;
        endcase
    end

    assign PRDATA = PSEL ? rdata : '0;

    // Access-done flag: the bridge holds acc high, so commit only once per select.
    always_ff @(posedge ACLK) begin
        if (ARESET)      done <= 1'b0;
        else if (!PSEL)  done <= 1'b0;
        else if (acc)    done <= 1'b1;
    end

    // CTRL fields; one-shot mode drops EN on expiry.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= '0;
        end else if (wr_ctrl) begin
            en          <= PWDATA[0];
            auto_reload <= PWDATA[1];
            irq_en      <= PWDATA[2];
            prescale    <= PWDATA[15:8];
        end else if (expire && !auto_reload) begin
            en          <= 1'b0;
        end
    end

    // Prescaler phase, restarted by LOAD writes and by enabling.
    always_ff @(posedge ACLK) begin
        if (ARESET)                         pre <= '0;
        else if (wr_load || start || !en)   pre <= '0;
        else if (tick)                      pre <= '0;
        else                                pre <= pre + 8'd1;
    end

    // LOAD/COUNT: a LOAD write reloads COUNT, ticks decrement or reload it.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            load  <= '0;
            count <= '0;
        end else if (wr_load) begin
            load  <= wdata_cnt;
            count <= wdata_cnt;
        end else if (tick_ok) begin
            if (count != '0)      count <= count - COUNT_WIDTH'(1);
            else if (auto_reload) count <= load;
        end
    end

    // EXPIRED sticky flag; a new expiry beats a same-cycle clear.
    always_ff @(posedge ACLK) begin
        if (ARESET)                        expired <= 1'b0;
        else if (expire)                   expired <= 1'b1;
        else if (wr_status && PWDATA[0])   expired <= 1'b0;
    end

    // Registered level interrupt.
    always_ff @(posedge ACLK) begin
        if (ARESET) IRQ <= 1'b0;
        else        IRQ <= expired & irq_en;
    end

`ifdef APB_TIMER_CAPTURE_EN
    // Two-flop synchronizer plus a registered rising-edge pulse.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cap_sync <= '0;
            cap_edge <= 1'b0;
        end else begin
            cap_sync <= {cap_sync[1:0], CAPTURE_IN};
            cap_edge <= cap_sync[1] & ~cap_sync[2];
        end
    end

    // Capture COUNT on each edge; CAP_VALID set beats a same-cycle clear.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cap       <= '0;
            cap_valid <= 1'b0;
        end else if (cap_edge) begin
            cap       <= count;
            cap_valid <= 1'b1;
        end else if (wr_status && PWDATA[1]) begin
            cap_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed stimulus for apb_timer, checked every cycle
// against a behavioural register-level model plus literal expectations.
module tb_apb_timer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PSLVERROR;
    logic        IRQ;
`ifdef APB_TIMER_CAPTURE_EN
    logic        CAPTURE_IN = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    bit checking = 0;

    apb_timer dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PWRITE(PWRITE),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PRDATA(PRDATA),
        .PSLVERROR(PSLVERROR),
`ifdef APB_TIMER_CAPTURE_EN
        .CAPTURE_IN(CAPTURE_IN),
`endif
        .IRQ(IRQ)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_en, m_ar, m_ie, m_exp, m_irq, m_done, m_capv;
    logic [7:0]  m_psc;
    logic [31:0] m_load, m_cnt, m_cap;
    int          m_wait;
    logic [3:0]  ci_hist;

    function automatic bit m_err(input logic [31:0] a, input logic w,
                                 input logic s, input logic e);
        logic [11:0] o;
        bit mp;
        o  = a[11:0];
        mp = (o == 12'h000) || (o == 12'h004) || (o == 12'h008) || (o == 12'h00C);
`ifdef APB_TIMER_CAPTURE_EN
        mp = mp || (o == 12'h010);
`endif
        return s && e && ((a[1:0] != 2'b00) || !mp ||
                          (w && (o == 12'h008 || o == 12'h010)));
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[11:0])
            12'h000: return {16'h0, m_psc, 5'h0, m_ie, m_ar, m_en};
            12'h004: return m_load;
            12'h008: return m_cnt;
            12'h00C: return {30'h0, m_capv, m_exp};
`ifdef APB_TIMER_CAPTURE_EN
            12'h010: return m_cap;
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge ACLK) begin
        bit acc, cm, wc, wl, ws, tick, fire, setx, setc, was_en;
        logic [11:0] o;
        if (ARESET) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_irq = 0;
            m_done = 0; m_capv = 0; m_psc = 0; m_load = 0;
            m_cnt = 0; m_cap = 0; m_wait = 0; ci_hist = 0;
        end else begin
            acc  = PSEL && PENABLE;
            o    = PADDR[11:0];
            cm   = acc && !m_done && PWRITE && !m_err(PADDR, PWRITE, PSEL, PENABLE);
            wc   = cm && o == 12'h000;
            wl   = cm && o == 12'h004;
            ws   = cm && o == 12'h00C;
            tick = m_en && m_wait == 0;
            fire = tick && !wc && !wl;
            was_en = m_en;
            m_irq = m_exp && m_ie;
            setc = 0;
`ifdef APB_TIMER_CAPTURE_EN
            if (ci_hist[2] && !ci_hist[3]) begin
                m_cap = m_cnt;
                setc = 1;
            end
            ci_hist = {ci_hist[2:0], CAPTURE_IN};
`endif
            if (setc) m_capv = 1;
            else if (ws && PWDATA[1]) m_capv = 0;
            if (wc) begin
                m_en = PWDATA[0]; m_ar = PWDATA[1];
                m_ie = PWDATA[2]; m_psc = PWDATA[15:8];
            end
            if (wl) begin
                m_load = PWDATA;
                m_cnt = PWDATA;
            end
            setx = 0;
            if (fire) begin
                if (m_cnt == 0) begin
                    setx = 1;
                    m_exp = 1;
                    if (m_ar) m_cnt = m_load;
                    else m_en = 0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            if (ws && PWDATA[0] && !setx) m_exp = 0;
            if (wl || (wc && !was_en && PWDATA[0]) || tick) m_wait = m_psc;
            else if (was_en) m_wait = m_wait - 1;
            if (!PSEL) m_done = 0;
            else if (acc) m_done = 1;
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge ACLK) begin
        if (checking) begin
            chk("irq", IRQ, m_irq);
            chk("pslverror", PSLVERROR, m_err(PADDR, PWRITE, PSEL, PENABLE));
            chk("prdata", PRDATA, PSEL ? m_read(PADDR) : 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] smp [0:31];
    logic        smp_irq [0:31];
    logic        last_err;
    logic [31:0] d;
    logic        e;
    int          fi;

    task automatic idle(input int n);
        repeat (n) begin @(posedge ACLK); #1; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input int n);
        PADDR = a; PWDATA = wd; PWRITE = 1; PSEL = 1; PENABLE = 0;
        @(posedge ACLK); #1;
        PENABLE = 1;
        @(negedge ACLK);
        last_err = PSLVERROR;
        repeat (n) begin @(posedge ACLK); #1; end
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        @(posedge ACLK); #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] rdat, output logic rerr);
        PADDR = a; PWRITE = 0; PSEL = 1; PENABLE = 0;
        @(posedge ACLK); #1;
        PENABLE = 1;
        @(negedge ACLK);
        rdat = PRDATA;
        rerr = PSLVERROR;
        @(posedge ACLK); #1;
        PSEL = 0; PENABLE = 0;
        @(posedge ACLK); #1;
    endtask

    task automatic peek(input logic [31:0] a, input int n);
        PADDR = a; PWRITE = 0; PSEL = 1; PENABLE = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            smp[i] = PRDATA;
            smp_irq[i] = IRQ;
            @(posedge ACLK); #1;
        end
        PSEL = 0;
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_seq [0:12];
        exp_seq = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd5, 32'd4,
                    32'd3, 32'd2, 32'd1, 32'd0, 32'd5, 32'd4};

        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 0;
        checking = 1;
        @(negedge ACLK);
        chk("rst_irq", IRQ, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_slverr", PSLVERROR, 0);
        @(posedge ACLK); #1;
        rd(32'h0, d, e); chk("rst_ctrl", d, 0);
        rd(32'h4, d, e); chk("rst_load", d, 0);
        rd(32'h8, d, e); chk("rst_count", d, 0);
        rd(32'hC, d, e); chk("rst_status", d, 0);

        // auto-reload, PRESCALE=0, IRQ enabled
        wr(32'h4, 32'd5, 1);
        wr(32'h0, 32'h7, 1);
        peek(32'h8, 13);
        for (int i = 0; i < 13; i++) chk("t1_count_seq", smp[i], exp_seq[i]);
        fi = -1;
        for (int i = 0; i < 13; i++) if (fi < 0 && smp_irq[i]) fi = i;
        chk("t1_irq_first", fi, 6);
        wr(32'h0, 32'h0, 1);
        wr(32'hC, 32'h1, 1);

        // one-shot, PRESCALE=3
        wr(32'h4, 32'd3, 1);
        wr(32'h0, 32'h301, 1);
        peek(32'hC, 20);
        fi = -1;
        for (int i = 0; i < 20; i++) if (fi < 0 && smp[i][0]) fi = i;
        chk("t2_expiry_cycle", fi, 15);
        rd(32'h0, d, e); chk("t2_ctrl_en_off", d, 32'h300);
        rd(32'h8, d, e); chk("t2_count_zero", d, 0);

        // held STATUS clear; expiry lands in access cycle 2
        wr(32'h4, 32'd3, 1);
        wr(32'h0, 32'h1, 1);
        wr(32'hC, 32'h1, 4);
        chk("t3_hold_err", last_err, 0);
        rd(32'hC, d, e); chk("t3_set_wins", d, 1);
        wr(32'hC, 32'h1, 4);
        rd(32'hC, d, e); chk("t3_single_clear", d, 0);
        idle(40);
        rd(32'hC, d, e); chk("t3_no_reexpiry", d, 0);
        rd(32'h0, d, e); chk("t3_ctrl_off", d, 0);

        // error accesses
        wr(32'h4, 32'h77, 1);
        wr(32'h8, 32'h55, 1);
        chk("t4_wr_count_err", last_err, 1);
        rd(32'h8, d, e); chk("t4_count_kept", d, 32'h77); chk("t4_rd_count_ok", e, 0);
        wr(32'h2, 32'h99, 1);
        chk("t4_misalign_err", last_err, 1);
        rd(32'h4, d, e); chk("t4_load_kept", d, 32'h77);
        rd(32'h40, d, e); chk("t4_unmapped_data", d, 0); chk("t4_unmapped_err", e, 1);
        rd(32'h3, d, e); chk("t4_rd_misalign_err", e, 1);
        rd(32'h1000_0004, d, e); chk("t4_upper_ignored", d, 32'h77);
        rd(32'h10, d, e);
`ifdef APB_TIMER_CAPTURE_EN
        chk("t4_cap_rd_err", e, 0);
        wr(32'h10, 32'h1, 1);
        chk("t4_cap_wr_err", last_err, 1);
`else
        chk("t4_0x10_err", e, 1);
`endif

        // LOAD write collides with tick at COUNT=1
        wr(32'h4, 32'd3, 1);
        wr(32'h0, 32'h1, 1);
        wr(32'h4, 32'd10, 1);
        peek(32'h8, 1); chk("t5_count_after_load", smp[0], 9);
        peek(32'hC, 1); chk("t5_expired_unchanged", smp[0], 0);
        wr(32'h0, 32'h0, 1);
        wr(32'hC, 32'h1, 1);

        // LOAD write collides with the expiring tick
        wr(32'h4, 32'd2, 1);
        wr(32'h0, 32'h1, 1);
        wr(32'h4, 32'd10, 1);
        peek(32'hC, 1); chk("t5b_expiry_dropped", smp[0], 0);
        peek(32'h8, 1); chk("t5b_count", smp[0], 7);
        wr(32'h0, 32'h0, 1);

`ifdef APB_TIMER_CAPTURE_EN
        wr(32'h4, 32'h40, 1);
        wr(32'h0, 32'h1, 1);
        idle(31);
        CAPTURE_IN = 1;
        idle(2);
        CAPTURE_IN = 0;
        idle(6);
        rd(32'h10, d, e); chk("t6_capture", d, 32'h1D);
        rd(32'hC, d, e); chk("t6_cap_valid", d[1], 1);
        wr(32'h0, 32'h0, 1);
`endif

        idle(2);
        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
